alu_ctrl_seq: RTL

//  Parametrised, registered ALU controller for the multi-cycle datapath. Decodes ALUOp_i/funct_i

---
 rtl/alu_ctrl_seq_if.sv | 27 ++
 rtl/alu_ctrl_seq.sv | 138 +++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq_if.sv
// Decoder-to-ALU-controller bus: decoded op in, ALU control code and sequencing strobes out.
interface alu_ctrl_seq_if #(
  parameter int FUNCT_W = 6,
  parameter int ALUOP_W = 3,
  parameter int CTRL_W  = 4
);
  logic               valid_i;
  logic [ALUOP_W-1:0] ALUOp_i;
  logic [FUNCT_W-1:0] funct_i;
  logic               ready_o;
  logic               stall_o;
  logic [CTRL_W-1:0]  ALUCtrl_o;
  logic               ctrl_valid_o;
  logic               step_o;
  logic               hilo_we_o;
  logic               illegal_o;

  modport master (
    output valid_i, ALUOp_i, funct_i,
    input  ready_o, stall_o, ALUCtrl_o, ctrl_valid_o, step_o, hilo_we_o, illegal_o
  );

  modport slave (
    input  valid_i, ALUOp_i, funct_i,
    output ready_o, stall_o, ALUCtrl_o, ctrl_valid_o, step_o, hilo_we_o, illegal_o
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder with mult/div sequencing; latency 1 (mult/div: MULDIV_CYCLES+1).
// Backpressure: ready drops for the whole iteration phase; valid without ready is dropped, not queued.
module alu_ctrl_seq #(
  parameter int FUNCT_W       = 6,
  parameter int ALUOP_W       = 3,
  parameter int CTRL_W        = 4,
  parameter int MULDIV_CYCLES = 32,
  parameter int CNT_W         = 6
) (
  input logic          clk_i,
  input logic          rst_i,
  alu_ctrl_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t            state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [CTRL_W-1:0] ctrl_q, ctrl_n;
  logic              cv_q, cv_n;
  logic              step_q, step_n;
  logic              hilo_q, hilo_n;
  logic              ill_q, ill_n;

  logic [3:0] dec_code;
  logic       dec_ill;
  logic       dec_muldiv;
  logic       ready;
  logic       accept;

  assign ready  = (state_q == IDLE || state_q == DONE) && !rst_i;
  assign accept = bus.valid_i && ready;

  always_comb begin
    dec_code   = 4'b0000;
    dec_ill    = 1'b0;
    dec_muldiv = 1'b0;
    case (bus.ALUOp_i)
      ALUOP_W'(3'b000): dec_code = 4'b0010;
      ALUOP_W'(3'b001): dec_code = 4'b0110;
      ALUOP_W'(3'b010): dec_code = 4'b0001;
      ALUOP_W'(3'b011): dec_code = 4'b0000;
      ALUOP_W'(3'b100): dec_code = 4'b0111;
      ALUOP_W'(3'b111): begin
        case (bus.funct_i)
          FUNCT_W'(6'b100000): dec_code = 4'b0010;
          FUNCT_W'(6'b100010): dec_code = 4'b0110;
          FUNCT_W'(6'b100100): dec_code = 4'b0000;
          FUNCT_W'(6'b100101): dec_code = 4'b0001;
          FUNCT_W'(6'b101010): dec_code = 4'b0111;
          FUNCT_W'(6'b000000): dec_code = 4'b1000;
          FUNCT_W'(6'b000010): dec_code = 4'b1001;
          FUNCT_W'(6'b000100): dec_code = 4'b1010;
          FUNCT_W'(6'b000110): dec_code = 4'b1011;
          FUNCT_W'(6'b011000): begin
            dec_code   = 4'b1100;
            dec_muldiv = 1'b1;
          end
          FUNCT_W'(6'b011010): begin
            dec_code   = 4'b1101;
            dec_muldiv = 1'b1;
          end
          default: dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    ctrl_n  = ctrl_q;
    cv_n    = 1'b0;
    step_n  = 1'b0;
    hilo_n  = 1'b0;
    ill_n   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        // DONE behaves exactly like IDLE for a new accept, giving a zero-bubble handoff.
        state_n = IDLE;
        if (accept) begin
          if (dec_ill) begin
            ill_n = 1'b1;
          end else if (dec_muldiv) begin
            state_n = ITER;
            cnt_n   = CNT_W'(MULDIV_CYCLES - 1);
            ctrl_n  = CTRL_W'(dec_code);
            step_n  = 1'b1;
          end else begin
            ctrl_n = CTRL_W'(dec_code);
            cv_n   = 1'b1;
          end
        end
      end
      ITER: begin
        if (cnt_q != '0) begin
          cnt_n  = cnt_q - CNT_W'(1);
          step_n = 1'b1;
        end else begin
          state_n = DONE;
          hilo_n  = 1'b1;
          cv_n    = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      cv_q    <= 1'b0;
      step_q  <= 1'b0;
      hilo_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      ctrl_q  <= ctrl_n;
      cv_q    <= cv_n;
      step_q  <= step_n;
      hilo_q  <= hilo_n;
      ill_q   <= ill_n;
    end
  end

  assign bus.ready_o      = ready;
  assign bus.stall_o      = ~ready;
  assign bus.ALUCtrl_o    = ctrl_q;
  assign bus.ctrl_valid_o = cv_q;
  assign bus.step_o       = step_q;
  assign bus.hilo_we_o    = hilo_q;
  assign bus.illegal_o    = ill_q;

endmodule
